sum_bcd_conv: RTL



---
 rtl/sum_bcd_conv_pkg.sv | 32 +++
 rtl/sum_bcd_conv_seg7_enc.sv | 18 +
 rtl/sum_bcd_conv.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sum_bcd_conv_pkg.sv
// Shared types and constants for the signed-sum to BCD/seven-segment converter.
// Segment codes are active-low with bit0 = a through bit6 = g.
package sum_bcd_conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    localparam int BCD_LIMIT = 999;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = ~7'h40;

    localparam logic [0:9][6:0] SEG_DIGITS = {
        ~7'h3F, ~7'h06, ~7'h5B, ~7'h4F, ~7'h66,
        ~7'h6D, ~7'h7D, ~7'h07, ~7'h7F, ~7'h6F
    };

    // Double-dabble correction applied to every nibble before each shift.
    function automatic logic [11:0] bcd_add3(input logic [11:0] b);
        logic [11:0] r;
        for (int i = 0; i < 3; i++) begin
            r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3
                                                 : b[4*i +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/sum_bcd_conv_seg7_enc.sv
// Combinational BCD digit to active-low seven-segment encoder with blanking.
// Non-decimal nibbles display as blank.
module seg7_enc
    import sum_bcd_conv_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank && bcd <= 4'd9) begin
            seg = SEG_DIGITS[bcd];
        end
    end

endmodule

// File: rtl/sum_bcd_conv.sv
// Adds two signed operands and converts |sum| to three BCD digits by
// iterative shift-and-add-3, with sign, overflow and segment outputs.
module sum_bcd_conv
    import sum_bcd_conv_pkg::*;
#(
    parameter int W = 10
) (
    input  logic         CLOCK_50,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] opA,
    input  logic [W-1:0] opB,
    output logic         busy,
    output logic         done,
    output logic [3:0]   dig0,
    output logic [3:0]   dig1,
    output logic [3:0]   dig2,
    output logic         neg,
    output logic         overflow,
    output logic [6:0]   soma0,
    output logic [6:0]   soma1,
    output logic [6:0]   soma2,
    output logic [6:0]   SinalSoma
);

    localparam int CW = $clog2(W + 2);

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W:0]    mag_q, mag_d;
    logic [11:0]   bcd_q, bcd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          neg_r_q, neg_r_d;
    logic          ovf_r_q, ovf_r_d;
    logic [3:0]    dig0_q, dig0_d;
    logic [3:0]    dig1_q, dig1_d;
    logic [3:0]    dig2_q, dig2_d;
    logic          neg_q, neg_d;
    logic          ovf_q, ovf_d;

    logic [W:0]    sum;
    logic [W:0]    mag_ld;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        neg_r_d = neg_r_q;
        ovf_r_d = ovf_r_q;
        dig0_d  = dig0_q;
        dig1_d  = dig1_q;
        dig2_d  = dig2_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;

        sum    = {a_q[W-1], a_q} + {b_q[W-1], b_q};
        // Negating the most negative sum wraps to itself, which is the
        // correct unsigned magnitude 2**W.
        mag_ld = sum[W] ? -sum : sum;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = opA;
                    b_d     = opB;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                neg_r_d = sum[W];
                mag_d   = mag_ld;
                ovf_r_d = 32'(mag_ld) > BCD_LIMIT;
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                {bcd_d, mag_d} = {bcd_add3(bcd_q), mag_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W)) begin
                    state_d = ST_DONE;
                    dig0_d  = ovf_r_q ? 4'd0 : bcd_d[3:0];
                    dig1_d  = ovf_r_q ? 4'd0 : bcd_d[7:4];
                    dig2_d  = ovf_r_q ? 4'd0 : bcd_d[11:8];
                    neg_d   = neg_r_q & ~ovf_r_q;
                    ovf_d   = ovf_r_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mag_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            neg_r_q <= 1'b0;
            ovf_r_q <= 1'b0;
            dig0_q  <= '0;
            dig1_q  <= '0;
            dig2_q  <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            neg_r_q <= neg_r_d;
            ovf_r_q <= ovf_r_d;
            dig0_q  <= dig0_d;
            dig1_q  <= dig1_d;
            dig2_q  <= dig2_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign dig0     = dig0_q;
    assign dig1     = dig1_q;
    assign dig2     = dig2_q;
    assign neg      = neg_q;
    assign overflow = ovf_q;

    seg7_enc u_seg0 (
        .bcd   (dig0_q),
        .blank (1'b0),
        .seg   (soma0)
    );

    seg7_enc u_seg1 (
        .bcd   (dig1_q),
        .blank (dig2_q == 4'd0 && dig1_q == 4'd0),
        .seg   (soma1)
    );

    seg7_enc u_seg2 (
        .bcd   (dig2_q),
        .blank (dig2_q == 4'd0),
        .seg   (soma2)
    );

    assign SinalSoma = neg_q ? SEG_MINUS : SEG_BLANK;

endmodule
